// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the buffered UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_e;

    localparam int   DATA_BITS            = 8;
    localparam logic START_LEVEL          = 1'b0;
    localparam logic STOP_LEVEL           = 1'b1;
    localparam logic IDLE_LEVEL           = 1'b1;
    // 70 MHz system clock, 9600 bps link
    localparam int   DEFAULT_CLKS_PER_BIT = 7292;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte push side and serial side of the buffered UART transmitter
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 3
);

    logic               i_WrEn;
    logic [7:0]         i_WrByte;
    logic               o_Full;
    logic               o_Empty;
    logic [FIFO_AW:0]   o_Count;
    logic               o_Overflow;
    logic               o_TxSerial;
    logic               o_TxActive;
    logic               o_TxDone;

    modport master (
        output i_WrEn, i_WrByte,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_TxSerial, o_TxActive, o_TxDone
    );

    modport slave (
        input  i_WrEn, i_WrByte,
        output o_Full, o_Empty, o_Count, o_Overflow, o_TxSerial, o_TxActive, o_TxDone
    );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO; a write while full is accepted only alongside a pop
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic [7:0]  wrData,
    input  logic        pop,
    output logic [7:0]  rdData,
    output logic        dropped,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPop;
    logic          doPush;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign doPush  = wrEn && (!full || doPop);
    assign dropped = wrEn && !doPush;
    assign rdData  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 LSB-first transmitter fed from a byte FIFO
// The line level is registered from the next state so a pop drives the start bit on the same edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    txState_e          state, stateNext;
    logic [BAUD_W-1:0] baudCnt, baudNext;
    logic [2:0]        bitIdx, bitNext;
    logic [7:0]        shiftReg, shiftNext;
    logic              serialReg, serialNext;
    logic              activeReg;
    logic              doneReg, doneNext;
    logic              overflowReg;

    logic              pop;
    logic [7:0]        headByte;
    logic              fifoEmpty;
    logic              dropped;
    logic              baudLast;
    logic              bitLast;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) fifo (
        .clk     (clk),
        .rst     (rst),
        .wrEn    (bus.i_WrEn),
        .wrData  (bus.i_WrByte),
        .pop     (pop),
        .rdData  (headByte),
        .dropped (dropped),
        .count   (bus.o_Count),
        .full    (bus.o_Full),
        .empty   (fifoEmpty)
    );

    assign bus.o_Empty    = fifoEmpty;
    assign bus.o_TxSerial = serialReg;
    assign bus.o_TxActive = activeReg;
    assign bus.o_TxDone   = doneReg;
    assign bus.o_Overflow = overflowReg;

    assign baudLast = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign bitLast  = (bitIdx == 3'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baudCnt     <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            serialReg   <= IDLE_LEVEL;
            activeReg   <= 1'b0;
            doneReg     <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            state       <= stateNext;
            baudCnt     <= baudNext;
            bitIdx      <= bitNext;
            shiftReg    <= shiftNext;
            serialReg   <= serialNext;
            activeReg   <= (stateNext != IDLE);
            doneReg     <= doneNext;
            overflowReg <= dropped;
        end
    end

    always_comb begin
        stateNext  = state;
        baudNext   = baudCnt;
        bitNext    = bitIdx;
        shiftNext  = shiftReg;
        serialNext = serialReg;
        doneNext   = 1'b0;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                baudNext   = '0;
                bitNext    = '0;
                serialNext = IDLE_LEVEL;
                if (!fifoEmpty) begin
                    pop        = 1'b1;
                    shiftNext  = headByte;
                    stateNext  = START;
                    serialNext = START_LEVEL;
                end
            end
            START: begin
                if (baudLast) begin
                    baudNext   = '0;
                    bitNext    = '0;
                    stateNext  = DATA;
                    serialNext = shiftReg[0];
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baudLast) begin
                    baudNext = '0;
                    if (bitLast) begin
                        bitNext    = '0;
                        stateNext  = STOP;
                        serialNext = STOP_LEVEL;
                    end else begin
                        bitNext    = bitIdx + 3'd1;
                        shiftNext  = {1'b0, shiftReg[7:1]};
                        serialNext = shiftReg[1];
                    end
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baudLast) begin
                    baudNext = '0;
                    doneNext = 1'b1;
                    // Chain straight into the next start bit so queued bytes leave no idle gap
                    if (!fifoEmpty) begin
                        pop        = 1'b1;
                        shiftNext  = headByte;
                        stateNext  = START;
                        serialNext = START_LEVEL;
                    end else begin
                        stateNext  = IDLE;
                        serialNext = IDLE_LEVEL;
                    end
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            default: begin
                stateNext  = IDLE;
                serialNext = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    uart_tx_fifo_if #(.FIFO_AW(3)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .FIFO_AW      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] frameOf(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Entered just after the edge at line position `first` of a frame (0 = start bit just driven).
    // Leaves just after the edge that ends STOP, having checked the done pulse there.
    task automatic checkFrame(input logic [9:0] frame, input int first,
                              input bit pushAtEnd, input logic [7:0] pushByte);
        for (int i = first; i < 10 * CPB; i++) begin
            chk("serial", bus.o_TxSerial, frame[i / CPB]);
            chk("active", bus.o_TxActive, 1);
            if (i > 0) chk("done_low", bus.o_TxDone, 0);
            if (i == 10 * CPB - 1 && pushAtEnd) begin
                bus.i_WrByte = pushByte;
                bus.i_WrEn   = 1'b1;
            end
            tick();
        end
        bus.i_WrEn = 1'b0;
        chk("done_pulse", bus.o_TxDone, 1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_WrEn   = 1'b0;
        bus.i_WrByte = 8'h00;

        // reset held for three edges
        repeat (3) tick();
        chk("rst_serial",   bus.o_TxSerial, 1);
        chk("rst_empty",    bus.o_Empty,    1);
        chk("rst_full",     bus.o_Full,     0);
        chk("rst_count",    bus.o_Count,    0);
        chk("rst_active",   bus.o_TxActive, 0);
        chk("rst_done",     bus.o_TxDone,   0);
        chk("rst_overflow", bus.o_Overflow, 0);

        // single byte 0xA5
        rst          = 1'b0;
        bus.i_WrByte = 8'hA5;
        bus.i_WrEn   = 1'b1;
        tick();
        bus.i_WrEn = 1'b0;
        chk("single_count_e0",  bus.o_Count,    1);
        chk("single_serial_e0", bus.o_TxSerial, 1);
        chk("single_active_e0", bus.o_TxActive, 0);
        tick();
        chk("single_count_e1", bus.o_Count, 0);
        chk("single_empty_e1", bus.o_Empty, 1);
        checkFrame(10'h34A, 0, 1'b0, 8'h00);
        chk("single_active_end", bus.o_TxActive, 0);
        chk("single_serial_end", bus.o_TxSerial, 1);
        tick();
        chk("single_done_once", bus.o_TxDone, 0);

        // back-to-back 0x00, 0xFF, 0x55
        bus.i_WrByte = 8'h00;
        bus.i_WrEn   = 1'b1;
        tick();
        chk("b2b_count_e0", bus.o_Count, 1);
        bus.i_WrByte = 8'hFF;
        tick();
        chk("b2b_count_e1",  bus.o_Count,    1);
        chk("b2b_serial_e1", bus.o_TxSerial, 0);
        bus.i_WrByte = 8'h55;
        tick();
        bus.i_WrEn = 1'b0;
        chk("b2b_count_e2", bus.o_Count, 2);
        checkFrame(10'h200, 1, 1'b0, 8'h00);
        chk("b2b_count_2nd_pop", bus.o_Count, 1);
        chk("b2b_empty_2nd_pop", bus.o_Empty, 0);
        checkFrame(10'h3FE, 0, 1'b0, 8'h00);
        chk("b2b_count_3rd_pop", bus.o_Count, 0);
        chk("b2b_empty_3rd_pop", bus.o_Empty, 1);
        checkFrame(10'h2AA, 0, 1'b0, 8'h00);
        chk("b2b_active_end", bus.o_TxActive, 0);
        chk("b2b_serial_end", bus.o_TxSerial, 1);
        tick();

        // fill and overflow: ten pushes 0x30..0x39, the last dropped
        for (int k = 0; k < 10; k++) begin
            bus.i_WrByte = 8'(8'h30 + k);
            bus.i_WrEn   = 1'b1;
            tick();
            if (k == 7) chk("fill_full_e7", bus.o_Full, 0);
            if (k == 8) begin
                chk("fill_count_e8", bus.o_Count,    8);
                chk("fill_full_e8",  bus.o_Full,     1);
                chk("fill_ovf_e8",   bus.o_Overflow, 0);
            end
            if (k == 9) begin
                chk("fill_ovf_e9",   bus.o_Overflow, 1);
                chk("fill_count_e9", bus.o_Count,    8);
            end
        end
        bus.i_WrEn = 1'b0;
        tick();
        chk("fill_ovf_e10", bus.o_Overflow, 0);
        // push on the last STOP cycle of frame 0 while full: accepted with the pop
        checkFrame(frameOf(8'h30), 9, 1'b1, 8'h3A);
        chk("fullpop_count", bus.o_Count,    8);
        chk("fullpop_ovf",   bus.o_Overflow, 0);
        chk("fullpop_full",  bus.o_Full,     1);
        for (int k = 1; k < 9; k++) begin
            checkFrame(frameOf(8'(8'h30 + k)), 0, 1'b0, 8'h00);
        end
        checkFrame(frameOf(8'h3A), 0, 1'b0, 8'h00);
        chk("fill_active_end", bus.o_TxActive, 0);
        chk("fill_serial_end", bus.o_TxSerial, 1);
        chk("fill_empty_end",  bus.o_Empty,    1);
        tick();

        // reset during DATA bit 3 with four bytes queued
        for (int k = 0; k < 5; k++) begin
            bus.i_WrByte = 8'(8'h60 + k);
            bus.i_WrEn   = 1'b1;
            tick();
        end
        bus.i_WrEn = 1'b0;
        chk("midrst_count_q", bus.o_Count, 4);
        repeat (14) tick();
        chk("midrst_serial_bit3", bus.o_TxSerial, 0);
        chk("midrst_active_pre",  bus.o_TxActive, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_serial", bus.o_TxSerial, 1);
        chk("midrst_count",  bus.o_Count,    0);
        chk("midrst_empty",  bus.o_Empty,    1);
        chk("midrst_active", bus.o_TxActive, 0);
        chk("midrst_done",   bus.o_TxDone,   0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("midrst_idle_serial", bus.o_TxSerial, 1);
            chk("midrst_idle_active", bus.o_TxActive, 0);
            chk("midrst_idle_done",   bus.o_TxDone,   0);
        end
        bus.i_WrByte = 8'hC3;
        bus.i_WrEn   = 1'b1;
        tick();
        bus.i_WrEn = 1'b0;
        chk("postrst_count_e0", bus.o_Count, 1);
        tick();
        checkFrame(frameOf(8'hC3), 0, 1'b0, 8'h00);
        chk("postrst_active_end", bus.o_TxActive, 0);
        chk("postrst_serial_end", bus.o_TxSerial, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
